// File: rtl/temp_bcd_conv.sv
// DS18B20 raw temperature (Q12.4 two's complement) to sign + 4-digit BCD (XXX.X degC).
// One conversion at a time: scale to tenths, saturate, then 14-step double-dabble.
module temp_bcd_conv #(
  parameter logic [3:0]  POS_CODE = 4'h0,
  parameter logic [3:0]  NEG_CODE = 4'hF,
  parameter logic [13:0] MAX_VAL  = 14'd9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_raw,
  input  logic        temp_vld,
  output logic        conv_ready,
  output logic [19:0] dout,
  output logic        dout_vld
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_raw;
  logic        r_neg;
  logic [13:0] r_val;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [19:0] r_dout;
  logic        r_dout_vld;

  logic [15:0] w_mag;
  logic [19:0] w_prod;
  logic [19:0] w_quot;
  logic [13:0] w_val_sat;
  logic        w_neg;
  logic [15:0] w_bcd_adj;
  logic [15:0] w_bcd_shift;
  logic [13:0] w_val_shift;
  logic        w_last_shift;

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

  // Scaling datapath: |raw| * 10 / 16 truncates toward zero, 0x8000 maps to 32768.
  always_comb begin
    w_mag     = r_raw[15] ? (~r_raw + 16'd1) : r_raw;
    w_prod    = {4'd0, w_mag} * 20'd10;
    w_quot    = w_prod >> 4;
    w_val_sat = (w_quot > {6'd0, MAX_VAL}) ? MAX_VAL : w_quot[13:0];
    w_neg     = r_raw[15] && (w_val_sat != 14'd0);
  end

  // One double-dabble step on the {bcd, val} pair.
  always_comb begin
    w_bcd_adj    = bcd_adjust(r_bcd);
    w_bcd_shift  = {w_bcd_adj[14:0], r_val[13]};
    w_val_shift  = {r_val[12:0], 1'b0};
    w_last_shift = (r_cnt == 4'd13);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (temp_vld) begin
          w_state_nxt = S_SCALE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCALE: w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (w_last_shift) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers and the registered result/strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw      <= 16'd0;
      r_neg      <= 1'b0;
      r_val      <= 14'd0;
      r_bcd      <= 16'd0;
      r_cnt      <= 4'd0;
      r_dout     <= 20'h00000;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (temp_vld) begin
            r_raw <= temp_raw;
          end
        end
        S_SCALE: begin
          r_val <= w_val_sat;
          r_neg <= w_neg;
          r_bcd <= 16'd0;
          r_cnt <= 4'd0;
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_shift;
          r_val <= w_val_shift;
          r_cnt <= r_cnt + 4'd1;
          if (w_last_shift) begin
            r_dout     <= {(r_neg ? NEG_CODE : POS_CODE), w_bcd_shift};
            r_dout_vld <= 1'b1;
          end
        end
        S_DONE: begin
          r_dout_vld <= 1'b0;
        end
        default: begin
          r_dout_vld <= 1'b0;
        end
      endcase
    end
  end

  assign conv_ready = (r_state == S_IDLE);
  assign dout       = r_dout;
  assign dout_vld   = r_dout_vld;

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Scoreboard bench for temp_bcd_conv: stimulus pushes hand-computed expectations on accept,
// an independent negedge monitor pops and checks value and latency on every dout_vld.
module tb_temp_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] temp_raw = 16'h0000;
  logic        temp_vld = 1'b0;
  logic        conv_ready;
  logic [19:0] dout;
  logic        dout_vld;

  temp_bcd_conv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .temp_raw   (temp_raw),
    .temp_vld   (temp_vld),
    .conv_ready (conv_ready),
    .dout       (dout),
    .dout_vld   (dout_vld)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int idx   = 0;
  int n_vld = 0;
  logic prev_vld = 1'b0;

  typedef struct {
    logic [19:0] d;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] tbl_raw [10] = '{16'h0191, 16'h07D0, 16'h00A2, 16'hFC90, 16'hFFFF,
                                16'h7FFF, 16'h8000, 16'hFF5E, 16'h0001, 16'h000F};
  logic [19:0] tbl_exp [10] = '{20'h00250, 20'h01250, 20'h00101, 20'hF0550, 20'h00000,
                                20'h09999, 20'hF9999, 20'hF0101, 20'h00000, 20'h00009};

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops on every output strobe, records accepts seen on the coming edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      prev_vld = 1'b0;
    end else begin
      if (dout_vld) begin
        n_vld++;
        chk("vld_pulse_width", {19'd0, prev_vld}, 20'd0);
        if (sbq.size() == 0) begin
          chk("spurious_dout_vld", {19'd0, dout_vld}, 20'd0);
        end else begin
          e = sbq.pop_front();
          chk("dout", dout, e.d);
          chk_int("latency", cyc, e.acc + 15);
        end
      end
      if (conv_ready && temp_vld) begin
        sbq.push_back('{tbl_exp[idx], cyc + 1});
      end
      prev_vld = dout_vld;
    end
  end

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout waiting for dout_vld pending=%0d", name, sbq.size());
    end
  endtask

  task automatic issue(input int i);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    idx      = i;
    temp_raw = tbl_raw[i];
    temp_vld = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (conv_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=busy required=ready");
    end
    @(posedge clk);
    #1;
    temp_vld = 1'b0;
  endtask

  task automatic run_one(input int i);
    issue(i);
    drain("conv");
    repeat (3) @(negedge clk);
    chk("dout_hold", dout, tbl_exp[i]);
  endtask

  initial begin
    int nv0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dout", dout, 20'h00000);
    chk("reset_dout_vld", {19'd0, dout_vld}, 20'd0);
    chk("reset_conv_ready", {19'd0, conv_ready}, 20'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_one(i);

    // Continuous temp_vld with raw changing every cycle: 5 accepts in 85 clocks.
    nv0 = n_vld;
    @(posedge clk);
    #1;
    idx      = 0;
    temp_raw = tbl_raw[0];
    temp_vld = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      @(posedge clk);
      #1;
      idx      = (idx + 3) % 10;
      temp_raw = tbl_raw[idx];
    end
    temp_vld = 1'b0;
    drain("hold_vld");
    chk_int("hold_vld_count", n_vld - nv0, 5);

    // Reset asserted at E8 of a conversion.
    nv0 = n_vld;
    issue(3);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_dout", dout, 20'h00000);
    chk("midreset_dout_vld", {19'd0, dout_vld}, 20'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_conv_ready", {19'd0, conv_ready}, 20'd1);
    repeat (20) @(negedge clk);
    chk_int("midreset_no_vld", n_vld - nv0, 0);
    chk("midreset_dout_idle", dout, 20'h00000);
    run_one(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
